// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, error codes,
// default link timing constants and the odd-parity helper.
package ps2_pkg;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_INHIBIT  = 4'd1;
    localparam logic [3:0] S_REQ      = 4'd2;
    localparam logic [3:0] S_DATA     = 4'd3;
    localparam logic [3:0] S_PARITY   = 4'd4;
    localparam logic [3:0] S_STOP     = 4'd5;
    localparam logic [3:0] S_WAIT_REL = 4'd6;
    localparam logic [3:0] S_DONE     = 4'd7;
    localparam logic [3:0] S_ERR      = 4'd8;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_START  = 2'b01;
    localparam logic [1:0] ERR_PACKET = 2'b10;
    localparam logic [1:0] ERR_NOACK  = 2'b11;

    localparam int DEF_INHIBIT_CYCLES = 6000;
    localparam int DEF_DAT_LEAD       = 50;
    localparam int DEF_START_TIMEOUT  = 750000;
    localparam int DEF_PACKET_TIMEOUT = 100000;
    localparam int DEF_FILTER_LEN     = 8;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-FF synchroniser, FILTER_LEN glitch filter, fall strobe.
// Ports: clock, reset_n, i_raw (async pin), o_level (filtered), o_fall (1->0 strobe).
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_fall;

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious fall.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            r_fall <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_fall  <= r_level;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame, ack check.
// Ports: clock/reset_n, raw pins in, open-drain pull-low enables out, tx handshake.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int DAT_LEAD       = DEF_DAT_LEAD,
    parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
    parameter int PACKET_TIMEOUT = DEF_PACKET_TIMEOUT,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] error_code
);

    localparam logic [12:0] LP_INH_LAST = 13'(INHIBIT_CYCLES - 1);
    localparam logic [12:0] LP_LEAD_AT  = 13'(INHIBIT_CYCLES - DAT_LEAD - 1);
    localparam logic [19:0] LP_STA_LAST = 20'(START_TIMEOUT - 1);
    localparam logic [19:0] LP_PKT_LAST = 20'(PACKET_TIMEOUT - 1);

    logic        w_clk_level;
    logic        w_clk_fall;
    logic        w_dat_level;
    logic        w_dat_fall_unused;
    logic [12:0] w_inh_inc;
    logic [19:0] w_to_inc;
    logic        w_in_pkt;
    logic        w_pkt_to;

    logic [3:0]  r_state;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic [3:0]  r_bit_idx;
    logic [12:0] r_inh_cnt;
    logic [19:0] r_to_cnt;
    logic        r_clk_oe;
    logic        r_dat_oe;
    logic [1:0]  r_err_code;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clock   (clock),
        .reset_n (reset_n),
        .i_raw   (ps2_clk_i),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clock   (clock),
        .reset_n (reset_n),
        .i_raw   (ps2_dat_i),
        .o_level (w_dat_level),
        .o_fall  (w_dat_fall_unused)
    );

    assign w_inh_inc = (r_inh_cnt == '1) ? r_inh_cnt : r_inh_cnt + 13'd1;
    assign w_to_inc  = (r_to_cnt == '1) ? r_to_cnt : r_to_cnt + 20'd1;

    assign w_in_pkt = (r_state == S_DATA) || (r_state == S_PARITY) ||
                      (r_state == S_STOP) || (r_state == S_WAIT_REL);
    assign w_pkt_to = w_in_pkt && (r_to_cnt == LP_PKT_LAST);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_bit_idx  <= '0;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
            r_clk_oe   <= 1'b0;
            r_dat_oe   <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tx_start) begin
                        r_shift    <= tx_data;
                        r_parity   <= odd_parity(tx_data);
                        r_bit_idx  <= '0;
                        r_inh_cnt  <= '0;
                        r_to_cnt   <= '0;
                        r_err_code <= ERR_NONE;
                        r_clk_oe   <= 1'b1;
                        r_dat_oe   <= 1'b0;
                        r_state    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    // DAT goes low DAT_LEAD cycles before CLK is released;
                    // that low level is the start bit.
                    if (r_inh_cnt == LP_INH_LAST) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b1;
                        r_to_cnt <= '0;
                        r_state  <= S_REQ;
                    end else begin
                        if (r_inh_cnt >= LP_LEAD_AT) begin
                            r_dat_oe <= 1'b1;
                        end
                        r_inh_cnt <= w_inh_inc;
                    end
                end
                S_REQ: begin
                    // First device fall: start bit is taken, present d0.
                    if (w_clk_fall) begin
                        r_dat_oe  <= ~r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                        r_to_cnt  <= '0;
                        r_state   <= S_DATA;
                    end else if (r_to_cnt == LP_STA_LAST) begin
                        r_dat_oe   <= 1'b0;
                        r_err_code <= ERR_START;
                        r_state    <= S_ERR;
                    end else begin
                        r_to_cnt <= w_to_inc;
                    end
                end
                S_DATA: begin
                    r_to_cnt <= w_to_inc;
                    // r_bit_idx is the index of the bit currently on DAT.
                    if (w_clk_fall) begin
                        if (r_bit_idx == 4'd7) begin
                            r_dat_oe <= ~r_parity;
                            r_state  <= S_PARITY;
                        end else begin
                            r_dat_oe  <= ~r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    r_to_cnt <= w_to_inc;
                    if (w_clk_fall) begin
                        r_dat_oe <= 1'b0;
                        r_state  <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_to_cnt <= w_to_inc;
                    if (w_clk_fall) begin
                        if (!w_dat_level) begin
                            r_state <= S_WAIT_REL;
                        end else begin
                            r_err_code <= ERR_NOACK;
                            r_state    <= S_ERR;
                        end
                    end
                end
                S_WAIT_REL: begin
                    r_to_cnt <= w_to_inc;
                    if (w_clk_level && w_dat_level) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase

            // A stalled device overrides whatever the frame step decided.
            if (w_pkt_to) begin
                r_clk_oe   <= 1'b0;
                r_dat_oe   <= 1'b0;
                r_err_code <= ERR_PACKET;
                r_state    <= S_ERR;
            end
        end
    end

    assign ps2_clk_oe = r_clk_oe;
    assign ps2_dat_oe = r_dat_oe;
    assign tx_busy    = (r_state != S_IDLE);
    assign tx_done    = (r_state == S_DONE);
    assign tx_error   = (r_state == S_ERR);
    assign error_code = r_err_code;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device model.
// Shortened timing parameters keep the run small.
module tb_ps2_host_tx;

    localparam int IC   = 200;
    localparam int DL   = 20;
    localparam int ST   = 3000;
    localparam int PT   = 4000;
    localparam int FL   = 4;
    localparam int HALF = 40;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       clk_line;
    logic       dat_line;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic [1:0] error_code;

    always #10 clock = ~clock;

    assign clk_line = !(ps2_clk_oe || dev_clk_low);
    assign dat_line = !(ps2_dat_oe || dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (IC),
        .DAT_LEAD       (DL),
        .START_TIMEOUT  (ST),
        .PACKET_TIMEOUT (PT),
        .FILTER_LEN     (FL)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .ps2_clk_i  (clk_line),
        .ps2_dat_i  (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .error_code (error_code)
    );

    // ref: 0 none, 1 latency from CLK release, 2 latency from first data edge
    typedef struct {
        bit       is_err;
        bit [1:0] code;
        int       ref_kind;
        int       lat;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_checks = 0;
    int   cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok,
                         input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: inhibit/lead lengths and the scoreboard pop on done/error.
    int run_len = 0;
    int lead_len = 0;
    int rel_cyc = 0;
    int data_cyc = 0;
    bit seen_data = 1'b0;
    bit prev_clk_oe = 1'b0;
    bit prev_dat_oe = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            run_len = 0;
            lead_len = 0;
        end else if (ps2_clk_oe === 1'b1) begin
            run_len++;
            if (ps2_dat_oe === 1'b1) lead_len++;
        end else if (prev_clk_oe) begin
            check("inhibit_len", run_len == IC, run_len, IC);
            check("dat_lead", lead_len == DL, lead_len, DL);
            rel_cyc = cyc;
            seen_data = 1'b0;
            run_len = 0;
            lead_len = 0;
        end
        if (!ps2_clk_oe && prev_dat_oe && !ps2_dat_oe && !seen_data && tx_busy) begin
            data_cyc = cyc;
            seen_data = 1'b1;
        end
        if (tx_done === 1'b1 || tx_error === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", 1'b0, {tx_done, tx_error}, 0);
            end else begin
                e = q.pop_front();
                check("result_kind", tx_error == e.is_err, tx_error, e.is_err);
                check("result_code", error_code == e.code, error_code, e.code);
                check("lines_released", !ps2_clk_oe && !ps2_dat_oe,
                      {ps2_clk_oe, ps2_dat_oe}, 0);
                if (e.ref_kind == 1)
                    check("start_timeout_lat", cyc - rel_cyc == e.lat,
                          cyc - rel_cyc, e.lat);
                if (e.ref_kind == 2)
                    check("packet_timeout_lat", cyc - data_cyc == e.lat,
                          cyc - data_cyc, e.lat);
            end
        end
        prev_clk_oe = (ps2_clk_oe === 1'b1);
        prev_dat_oe = (ps2_dat_oe === 1'b1);
    end

    task automatic send(input logic [7:0] b);
        @(negedge clock);
        tx_data = b;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (!tx_busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!ok) check(name, 1'b0, tx_busy, 0);
        repeat (5) @(negedge clock);
    endtask

    // Device: waits for the request, then clocks nfalls pulses, sampling
    // DAT at the end of each low phase; acks on the 11th fall if asked.
    task automatic dev_frame(input logic [7:0] b, input logic p,
                             input int nfalls, input bit ack);
        logic [9:0] rx = '0;
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ps2_clk_oe) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < IC + 50; i++) begin
                if (!ps2_clk_oe) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clock);
            end
        end
        if (!ok) begin
            check("request_seen", 1'b0, ps2_clk_oe, 0);
            return;
        end
        repeat (20) @(negedge clock);
        for (int k = 1; k <= nfalls; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF - 1) @(negedge clock);
            if (k <= 10) rx[k-1] = dat_line;
            @(negedge clock);
            dev_clk_low = 1'b0;
            if (k == 10 && ack) dev_dat_low = 1'b1;
            repeat (HALF) @(negedge clock);
            if (k == 11) dev_dat_low = 1'b0;
        end
        if (nfalls == 11) begin
            check("rx_byte", rx[7:0] == b, rx[7:0], b);
            check("rx_parity", rx[8] == p, rx[8], p);
            check("rx_stop", rx[9] == 1'b1, rx[9], 1);
        end
    endtask

    typedef struct {
        logic [7:0] b;
        logic       p;
    } vec_t;

    vec_t vecs[4] = '{
        '{8'hED, 1'b1},
        '{8'h00, 1'b1},
        '{8'hFF, 1'b1},
        '{8'h01, 1'b0}
    };

    initial begin
        repeat (3) @(negedge clock);
        check("reset_outputs",
              {tx_busy, ps2_clk_oe, ps2_dat_oe, tx_done, tx_error, error_code} == 7'd0,
              {tx_busy, ps2_clk_oe, ps2_dat_oe, tx_done, tx_error, error_code}, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);

        foreach (vecs[i]) begin
            q.push_back('{1'b0, 2'b00, 0, 0});
            send(vecs[i].b);
            dev_frame(vecs[i].b, vecs[i].p, 11, 1'b1);
            wait_idle("frame_end");
        end

        q.push_back('{1'b1, 2'b01, 1, ST});
        send(8'hED);
        dev_frame(8'hED, 1'b1, 0, 1'b0);
        wait_idle("start_timeout_end");

        q.push_back('{1'b1, 2'b11, 0, 0});
        send(8'h5A);
        dev_frame(8'h5A, 1'b1, 11, 1'b0);
        wait_idle("noack_end");

        q.push_back('{1'b1, 2'b10, 2, PT});
        send(8'hA5);
        dev_frame(8'hA5, 1'b1, 4, 1'b0);
        wait_idle("stall_end");

        q.push_back('{1'b0, 2'b00, 0, 0});
        send(8'h3C);
        fork
            dev_frame(8'h3C, 1'b1, 11, 1'b1);
            begin
                repeat (IC + 20 + 12 * HALF) @(negedge clock);
                check("busy_mid_frame", tx_busy == 1'b1, tx_busy, 1);
                tx_data = 8'h55;
                tx_start = 1'b1;
                @(negedge clock);
                tx_start = 1'b0;
                tx_data = 8'h00;
            end
        join
        wait_idle("ignored_start_end");
        repeat (10) @(negedge clock);
        check("no_queued_frame", {tx_busy, ps2_clk_oe} == 2'b00,
              {tx_busy, ps2_clk_oe}, 0);

        send(8'h0F);
        dev_frame(8'h0F, 1'b1, 5, 1'b0);
        check("pre_reset_busy_dat", {tx_busy, ps2_dat_oe} == 2'b11,
              {tx_busy, ps2_dat_oe}, 3);
        reset_n = 1'b0;
        @(negedge clock);
        check("mid_reset_release",
              {tx_busy, ps2_clk_oe, ps2_dat_oe, error_code} == 5'd0,
              {tx_busy, ps2_clk_oe, ps2_dat_oe, error_code}, 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clock);

        q.push_back('{1'b0, 2'b00, 0, 0});
        send(8'hED);
        dev_frame(8'hED, 1'b1, 11, 1'b1);
        wait_idle("post_reset_end");

        check("scoreboard_drained", q.size() == 0, q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
